// File: rtl/id_seg_if.sv
// Decode-stage bundle: fetch NPC/IR, hazard and write-back inputs in, ID/EX slot and stall out.
// master = upstream/environment side, slave = the decode stage.
interface id_seg_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
);
    logic [WIDTH-1:0] NPC;
    logic [WIDTH-1:0] IR;
    logic             flush;
    logic             ex_load;
    logic [AW-1:0]    ex_rt;
    logic             wb_en;
    logic [AW-1:0]    wb_addr;
    logic [WIDTH-1:0] wb_data;

    logic             stall;
    logic             id_valid;
    logic [WIDTH-1:0] id_NPC;
    logic [WIDTH-1:0] id_A;
    logic [WIDTH-1:0] id_B;
    logic [WIDTH-1:0] id_Imm;
    logic [WIDTH-1:0] id_JTgt;
    logic [5:0]       id_op;
    logic [5:0]       id_funct;
    logic [AW-1:0]    id_rs;
    logic [AW-1:0]    id_rt;
    logic [AW-1:0]    id_rd;

    modport master (
        output NPC, IR, flush, ex_load, ex_rt, wb_en, wb_addr, wb_data,
        input  stall, id_valid, id_NPC, id_A, id_B, id_Imm, id_JTgt,
               id_op, id_funct, id_rs, id_rt, id_rd
    );

    modport slave (
        input  NPC, IR, flush, ex_load, ex_rt, wb_en, wb_addr, wb_data,
        output stall, id_valid, id_NPC, id_A, id_B, id_Imm, id_JTgt,
               id_op, id_funct, id_rs, id_rt, id_rd
    );
endinterface

// File: rtl/id_seg.sv
// Instruction-decode stage: register file with write-through bypass, immediate/jump decode,
// load-use hazard detection and a registered ID/EX slot.
module id_seg #(
    parameter int          WIDTH  = 32,
    parameter int          NREG   = 32,
    parameter logic [31:0] NOP_IR = 32'h0
) (
    input  logic      clk,
    input  logic      rst,
    id_seg_if.slave   bus
);
    localparam int AW = $clog2(NREG);

    logic [5:0]       op;
    logic [5:0]       funct;
    logic [AW-1:0]    rs;
    logic [AW-1:0]    rt;
    logic [AW-1:0]    rd;

    assign op    = bus.IR[31:26];
    assign rs    = bus.IR[25:21];
    assign rt    = bus.IR[20:16];
    assign rd    = bus.IR[15:11];
    assign funct = bus.IR[5:0];

    // Register file; entry 0 is a constant so r0 can never hold anything but zero.
    logic [WIDTH-1:0] rf_rd [NREG];

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_rf
            if (gi == 0) begin : g_zero
                assign rf_rd[gi] = '0;
            end else begin : g_reg
                logic [WIDTH-1:0] q_reg;
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        q_reg <= '0;
                    end else if (bus.wb_en && (bus.wb_addr == AW'(gi))) begin
                        q_reg <= bus.wb_data;
                    end
                end
                assign rf_rd[gi] = q_reg;
            end
        end
    endgenerate

    logic [WIDTH-1:0] a_val;
    logic [WIDTH-1:0] b_val;

    // Same-cycle write-back is forwarded so decode never sees a stale value.
    assign a_val = (bus.wb_en && (bus.wb_addr == rs) && (rs != '0)) ? bus.wb_data : rf_rd[rs];
    assign b_val = (bus.wb_en && (bus.wb_addr == rt) && (rt != '0)) ? bus.wb_data : rf_rd[rt];

    logic [WIDTH-1:0] imm;

    always_comb begin
        imm = {{(WIDTH-16){bus.IR[15]}}, bus.IR[15:0]};
        case (op)
            6'h0C, 6'h0D, 6'h0E: imm = {{(WIDTH-16){1'b0}}, bus.IR[15:0]};
            6'h0F:               imm = {bus.IR[15:0], {(WIDTH-16){1'b0}}};
            default:             ;
        endcase
    end

    logic hazard;
    logic bubble;

    assign hazard    = bus.ex_load && (bus.ex_rt != '0) && ((bus.ex_rt == rs) || (bus.ex_rt == rt));
    assign bus.stall = hazard && !bus.flush;
    assign bubble    = hazard || bus.flush;

    logic             valid_reg, valid_next;
    logic [WIDTH-1:0] npc_reg, npc_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] imm_reg, imm_next;
    logic [WIDTH-1:0] jtgt_reg, jtgt_next;
    logic [5:0]       op_reg, op_next;
    logic [5:0]       funct_reg, funct_next;
    logic [AW-1:0]    rs_reg, rs_next;
    logic [AW-1:0]    rt_reg, rt_next;
    logic [AW-1:0]    rd_reg, rd_next;

    // A bubble carries NOP_IR's fields with every data word cleared.
    always_comb begin
        valid_next = 1'b0;
        npc_next   = '0;
        a_next     = '0;
        b_next     = '0;
        imm_next   = '0;
        jtgt_next  = '0;
        op_next    = NOP_IR[31:26];
        rs_next    = NOP_IR[25:21];
        rt_next    = NOP_IR[20:16];
        rd_next    = NOP_IR[15:11];
        funct_next = NOP_IR[5:0];
        if (!bubble) begin
            valid_next = 1'b1;
            npc_next   = bus.NPC;
            a_next     = a_val;
            b_next     = b_val;
            imm_next   = imm;
            jtgt_next  = {bus.NPC[WIDTH-1:WIDTH-4], bus.IR[25:0], 2'b00};
            op_next    = op;
            rs_next    = rs;
            rt_next    = rt;
            rd_next    = rd;
            funct_next = funct;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg <= 1'b0;
            npc_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            imm_reg   <= '0;
            jtgt_reg  <= '0;
            op_reg    <= '0;
            funct_reg <= '0;
            rs_reg    <= '0;
            rt_reg    <= '0;
            rd_reg    <= '0;
        end else begin
            valid_reg <= valid_next;
            npc_reg   <= npc_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            imm_reg   <= imm_next;
            jtgt_reg  <= jtgt_next;
            op_reg    <= op_next;
            funct_reg <= funct_next;
            rs_reg    <= rs_next;
            rt_reg    <= rt_next;
            rd_reg    <= rd_next;
        end
    end

    assign bus.id_valid = valid_reg;
    assign bus.id_NPC   = npc_reg;
    assign bus.id_A     = a_reg;
    assign bus.id_B     = b_reg;
    assign bus.id_Imm   = imm_reg;
    assign bus.id_JTgt  = jtgt_reg;
    assign bus.id_op    = op_reg;
    assign bus.id_funct = funct_reg;
    assign bus.id_rs    = rs_reg;
    assign bus.id_rt    = rt_reg;
    assign bus.id_rd    = rd_reg;
endmodule

// File: tb/tb_id_seg.sv
// Scoreboard bench for id_seg: expected ID/EX contents are queued when an instruction is
// presented and compared after the capturing edge.
module tb_id_seg;
    logic clk;
    logic rst;

    id_seg_if bus ();

    id_seg dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] npc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] jt;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Present one instruction, check stall before the edge, then compare the captured slot.
    task automatic issue(input logic [31:0] ir, input logic [31:0] npc, input logic v,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic exp_stall);
        exp_t e;
        exp_t got_e;
        e.v   = v;
        e.npc = v ? npc : 32'h0;
        e.a   = v ? a : 32'h0;
        e.b   = v ? b : 32'h0;
        e.imm = v ? imm : 32'h0;
        e.jt  = v ? {npc[31:28], ir[25:0], 2'b00} : 32'h0;
        e.op  = v ? ir[31:26] : 6'h0;
        e.fn  = v ? ir[5:0] : 6'h0;
        e.rs  = v ? ir[25:21] : 5'h0;
        e.rt  = v ? ir[20:16] : 5'h0;
        e.rd  = v ? ir[15:11] : 5'h0;
        sb.push_back(e);
        bus.IR  = ir;
        bus.NPC = npc;
        #1;
        chk("stall", {31'h0, bus.stall}, {31'h0, exp_stall});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'h1, 32'h0);
        end else begin
            got_e = sb.pop_front();
            chk("id_valid", {31'h0, bus.id_valid}, {31'h0, got_e.v});
            chk("id_NPC",   bus.id_NPC,   got_e.npc);
            chk("id_A",     bus.id_A,     got_e.a);
            chk("id_B",     bus.id_B,     got_e.b);
            chk("id_Imm",   bus.id_Imm,   got_e.imm);
            chk("id_JTgt",  bus.id_JTgt,  got_e.jt);
            chk("id_op",    {26'h0, bus.id_op},    {26'h0, got_e.op});
            chk("id_funct", {26'h0, bus.id_funct}, {26'h0, got_e.fn});
            chk("id_rs",    {27'h0, bus.id_rs},    {27'h0, got_e.rs});
            chk("id_rt",    {27'h0, bus.id_rt},    {27'h0, got_e.rt});
            chk("id_rd",    {27'h0, bus.id_rd},    {27'h0, got_e.rd});
            $display("txn ir=%h npc=%h valid=%0d A=%h B=%h Imm=%h JTgt=%h", ir, npc,
                     bus.id_valid, bus.id_A, bus.id_B, bus.id_Imm, bus.id_JTgt);
        end
        @(negedge clk);
    endtask

    task automatic quiet();
        bus.flush   = 1'b0;
        bus.ex_load = 1'b0;
        bus.ex_rt   = 5'h0;
        bus.wb_en   = 1'b0;
        bus.wb_addr = 5'h0;
        bus.wb_data = 32'h0;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_valid"}, {31'h0, bus.id_valid}, 32'h0);
        chk({tag, "_NPC"},   bus.id_NPC,  32'h0);
        chk({tag, "_A"},     bus.id_A,    32'h0);
        chk({tag, "_B"},     bus.id_B,    32'h0);
        chk({tag, "_Imm"},   bus.id_Imm,  32'h0);
        chk({tag, "_JTgt"},  bus.id_JTgt, 32'h0);
        chk({tag, "_fields"}, {bus.id_op, bus.id_funct, bus.id_rs, bus.id_rt, bus.id_rd, 5'h0}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with random traffic on every input.
        rst         = 1'b0;
        bus.IR      = $urandom;
        bus.NPC     = $urandom;
        bus.flush   = 1'($urandom);
        bus.ex_load = 1'($urandom);
        bus.ex_rt   = 5'($urandom);
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'($urandom_range(1, 31));
        bus.wb_data = $urandom;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        @(negedge clk);
        quiet();
        rst = 1'b1;

        // r5 reads zero after reset
        issue(32'h00A00820, 32'h00000100, 1'b1, 32'h0, 32'h0, 32'h00000820, 1'b0);

        // write r3, then read it
        bus.wb_en = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'hDEADBEEF;
        issue(32'h00000000, 32'h00000104, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
        quiet();
        issue(32'h00600820, 32'h00000108, 1'b1, 32'hDEADBEEF, 32'h0, 32'h00000820, 1'b0);

        // same-cycle bypass, then the stored value via rt
        bus.wb_en = 1'b1; bus.wb_addr = 5'd4; bus.wb_data = 32'h7;
        issue(32'h00800820, 32'h0000010C, 1'b1, 32'h7, 32'h0, 32'h00000820, 1'b0);
        quiet();
        issue(32'h00042020, 32'h00000110, 1'b1, 32'h0, 32'h7, 32'h00002020, 1'b0);

        // r0 writes are ignored, including the bypass path
        bus.wb_en = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'h5;
        issue(32'h00000820, 32'h00000114, 1'b1, 32'h0, 32'h0, 32'h00000820, 1'b0);
        quiet();
        issue(32'h00000820, 32'h00000118, 1'b1, 32'h0, 32'h0, 32'h00000820, 1'b0);

        // immediates and jump target
        issue(32'h2001FFFF, 32'h0000011C, 1'b1, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0);
        issue(32'h3401FFFF, 32'h00000120, 1'b1, 32'h0, 32'h0, 32'h0000FFFF, 1'b0);
        issue(32'h30018000, 32'h00000124, 1'b1, 32'h0, 32'h0, 32'h00008000, 1'b0);
        issue(32'h3C011234, 32'h00000128, 1'b1, 32'h0, 32'h0, 32'h12340000, 1'b0);
        issue(32'h08000010, 32'h40000004, 1'b1, 32'h0, 32'h0, 32'h00000010, 1'b0);
        chk("jtgt_j", bus.id_JTgt, 32'h40000040);

        // load-use on rs, on rt, with ex_rt=0, and without ex_load
        bus.ex_load = 1'b1; bus.ex_rt = 5'd2;
        issue(32'h00400820, 32'h00000130, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        bus.ex_rt = 5'd3;
        issue(32'h00030820, 32'h00000134, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        bus.ex_rt = 5'd0;
        issue(32'h00000820, 32'h00000138, 1'b1, 32'h0, 32'h0, 32'h00000820, 1'b0);
        quiet();
        issue(32'h00030820, 32'h0000013C, 1'b1, 32'h0, 32'hDEADBEEF, 32'h00000820, 1'b0);

        // flush over a stall, with a write-back in the same cycle
        bus.flush = 1'b1; bus.ex_load = 1'b1; bus.ex_rt = 5'd2;
        bus.wb_en = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'h9;
        issue(32'h00400820, 32'h00000140, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        quiet();
        issue(32'h00E00820, 32'h00000144, 1'b1, 32'h9, 32'h0, 32'h00000820, 1'b0);

        // asynchronous reset mid-operation clears without an edge and empties the file
        rst = 1'b0;
        #1;
        check_cleared("async_rst");
        @(negedge clk);
        rst = 1'b1;
        issue(32'h00600820, 32'h00000148, 1'b1, 32'h0, 32'h0, 32'h00000820, 1'b0);

        chk("sb_drained", sb.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
